load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 69 ++++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes and
// the bus sequencing state enumeration.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: lane enables,
// store data placement and load extraction with extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_e              size,
  input  logic               uns,
  input  logic [2:0]         addr_lo,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  rd0,
  input  logic [DATA_W-1:0]  rd1,
  output logic [DATA_W/8-1:0] be0,
  output logic [DATA_W/8-1:0] be1,
  output logic [DATA_W-1:0]  wd0,
  output logic [DATA_W-1:0]  wd1,
  output logic               two_beats,
  output logic [DATA_W-1:0]  ldata
);

  localparam int NB  = DATA_W / 8;
  localparam int NB2 = 2 * NB;

  logic [2:0]          off;
  logic [5:0]          sh;
  logic [3:0]          nbytes;
  logic [NB2-1:0]      lanes;
  logic [2*DATA_W-1:0] wsh;
  logic [DATA_W-1:0]   raw;
  logic [DATA_W-1:0]   lmask;
  logic                sgn;

  assign off    = addr_lo & 3'(NB - 1);
  assign sh     = {off, 3'b000};
  assign nbytes = 4'd1 << size;

  // Lanes over a two-word window; the upper half spills into beat 1
  assign lanes = NB2'((9'd1 << nbytes) - 9'd1) << off;
  assign {be1, be0} = lanes;
  assign two_beats  = |be1;

  assign wsh        = {{DATA_W{1'b0}}, wdata} << sh;
  assign {wd1, wd0} = wsh;

  assign raw = DATA_W'({rd1, rd0} >> sh);

  always_comb begin
    lmask = '1;
    sgn   = 1'b0;
    case (size)
      SZ_B: begin
        lmask = DATA_W'(8'hFF);
        sgn   = raw[7];
      end
      SZ_H: begin
        lmask = DATA_W'(16'hFFFF);
        sgn   = raw[15];
      end
      SZ_W: begin
        lmask = DATA_W'(32'hFFFF_FFFF);
        sgn   = raw[31];
      end
      default: ;
    endcase
    ldata = (raw & lmask) | ((sgn && !uns) ? ~lmask : '0);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, split into one or two
// bus beats, with sign/zero extension of load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_exc,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            state, nxt;
  logic              q_we, q_uns, q_exc;
  size_e             q_size;
  logic [31:0]       q_addr;
  logic [DATA_W-1:0] q_wdata, d0, d1;
  logic [2:0]        amask;
  logic              ill;
  logic [NB-1:0]     be0, be1;
  logic [DATA_W-1:0] wd0, wd1, ldata;
  logic              two;
  logic [31:0]       base;

  assign amask = 3'((4'd1 << req_size) - 4'd1);
  assign ill   = (DATA_W == 32 && req_size == 2'd3) ||
                 (!MISALIGN_SPLIT && |(req_addr[2:0] & amask));
  assign base  = {q_addr[31:OFF_W], {OFF_W{1'b0}}};

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size      (q_size),
    .uns       (q_uns),
    .addr_lo   (q_addr[2:0]),
    .wdata     (q_wdata),
    .rd0       (d0),
    .rd1       (d1),
    .be0       (be0),
    .be1       (be1),
    .wd0       (wd0),
    .wd1       (wd1),
    .two_beats (two),
    .ldata     (ldata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q_we    <= 1'b0;
      q_uns   <= 1'b0;
      q_exc   <= 1'b0;
      q_size  <= SZ_B;
      q_addr  <= '0;
      q_wdata <= '0;
      d0      <= '0;
      d1      <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        q_we    <= req_we;
        q_uns   <= req_unsigned;
        q_exc   <= ill;
        q_size  <= size_e'(req_size);
        q_addr  <= req_addr;
        q_wdata <= req_wdata;
        d0      <= '0;
        d1      <= '0;
      end
      if (state == BEAT0 && mem_ack) d0 <= mem_rdata;
      if (state == BEAT1 && mem_ack) d1 <= mem_rdata;
    end
  end

  always_comb begin
    nxt       = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) nxt = ill ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = q_we;
        mem_addr  = base;
        mem_be    = be0;
        mem_wdata = wd0;
        if (mem_ack) nxt = two ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = q_we;
        mem_addr  = base + 32'(NB);
        mem_be    = be1;
        mem_wdata = wd1;
        if (mem_ack) nxt = RESP;
      end
      RESP: nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_exc   = resp_valid && q_exc;
  assign resp_rdata = (resp_valid && !q_exc && !q_we) ? ldata : '0;

endmodule
